seq_multdiv: RTL and testbench

SEQ_MULTDIV -- requirements
Module: seq_multdiv

---
 rtl/seq_multdiv.sv | 164 ++++++++++++++++
 tb/tb_seq_multdiv.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multdiv.sv
// seq_multdiv: iterative multiplier (radix-2 shift-add) and restoring divider, one bit per cycle.
// Optional macro MULTDIV_SIGNED_EN selects two's-complement operands (sign/magnitude around the unsigned core).
module seq_multdiv #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start_mult,
   input  logic             start_div,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             busy,
   output logic             done,
   output logic             exception,
   output logic [1:0]       dbg_state
);

   // Handshake: a start is a one-cycle request taken only while busy is low (IDLE); there is no
   // back-pressure. done pulses for one cycle and result/result_hi/exception are valid from then on.
   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH);

   state_t state, state_next;

   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH-1:0]   a_raw;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH-1:0]   div_diff;
   logic [2*WIDTH-1:0] mul_step, div_step, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   logic [WIDTH-1:0]   fin_lo, fin_hi;
   logic               fin_exc, mul_exc, div_exc;
   logic               div_zero, accept, finish;
`ifdef MULTDIV_SIGNED_EN
   logic               neg_a, neg_b, ovf;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_mult) state_next = MUL;
                  else if (start_div) state_next = DIV;
         MUL:     if (cnt == LAST) state_next = DONE;
         DIV:     if (div_zero || cnt == LAST) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != IDLE);
      done      = (state == DONE);
      dbg_state = state;
   end

   always_comb begin
`ifdef MULTDIV_SIGNED_EN
      mag_a = op_a[WIDTH-1] ? -op_a : op_a;
      mag_b = op_b[WIDTH-1] ? -op_b : op_b;
`else
      mag_a = op_a;
      mag_b = op_b;
`endif
   end

   // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
   always_comb begin
      accept    = (state == IDLE) && (start_mult || start_div);
      finish    = (state == MUL || state == DIV) && (state_next == DONE);
      div_zero  = (opnd == '0);
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      mul_step  = {mul_sum, acc[WIDTH-1:1]};
      div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff  = div_shift[WIDTH-1:0] - opnd;
      if (div_shift >= {1'b0, opnd}) div_step = {div_diff, acc[WIDTH-2:0], 1'b1};
      else                           div_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
   end

   always_comb begin
      prod_fix = acc;
      quo_fix  = acc[WIDTH-1:0];
      rem_fix  = acc[2*WIDTH-1:WIDTH];
      mul_exc  = |acc[2*WIDTH-1:WIDTH];
      div_exc  = 1'b0;
`ifdef MULTDIV_SIGNED_EN
      if (neg_a ^ neg_b) begin
         prod_fix = -acc;
         quo_fix  = -acc[WIDTH-1:0];
      end
      if (neg_a) rem_fix = -acc[2*WIDTH-1:WIDTH];
      mul_exc = (prod_fix[2*WIDTH-1:WIDTH] != {WIDTH{prod_fix[WIDTH-1]}});
      div_exc = ovf;
`endif
      if (state == MUL) begin
         fin_lo  = prod_fix[WIDTH-1:0];
         fin_hi  = prod_fix[2*WIDTH-1:WIDTH];
         fin_exc = mul_exc;
      end else if (div_zero) begin
         fin_lo  = '1;
         fin_hi  = a_raw;
         fin_exc = 1'b1;
      end else begin
         fin_lo  = quo_fix;
         fin_hi  = rem_fix;
         fin_exc = div_exc;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt       <= '0;
         acc       <= '0;
         opnd      <= '0;
         a_raw     <= '0;
         result    <= '0;
         result_hi <= '0;
         exception <= 1'b0;
`ifdef MULTDIV_SIGNED_EN
         neg_a     <= 1'b0;
         neg_b     <= 1'b0;
         ovf       <= 1'b0;
`endif
      end else if (accept) begin
         cnt   <= '0;
         a_raw <= op_a;
         if (start_mult) begin
            opnd <= mag_a;
            acc  <= {{WIDTH{1'b0}}, mag_b};
         end else begin
            opnd <= mag_b;
            acc  <= {{WIDTH{1'b0}}, mag_a};
         end
`ifdef MULTDIV_SIGNED_EN
         neg_a <= op_a[WIDTH-1];
         neg_b <= op_b[WIDTH-1];
         ovf   <= !start_mult && (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&op_b);
`endif
      end else if (finish) begin
         result    <= fin_lo;
         result_hi <= fin_hi;
         exception <= fin_exc;
      end else if (state == MUL) begin
         acc <= mul_step;
         cnt <= cnt + CW'(1);
      end else if (state == DIV) begin
         acc <= div_step;
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_seq_multdiv.sv
// tb_seq_multdiv: scoreboard bench for seq_multdiv at WIDTH=4 (exhaustive) and WIDTH=8 (directed/random).
// Signed expectations are selected when MULTDIV_SIGNED_EN is defined.
module tb_seq_multdiv;

   logic clock;
   logic reset_n;

   logic       m8, d8, busy8, done8, exc8;
   logic [7:0] a8, b8, r8, rh8;
   logic [1:0] st8;
   logic       m4, d4, busy4, done4, exc4;
   logic [3:0] a4, b4, r4, rh4;
   logic [1:0] st4;

   int checks;
   int failures;

   logic [64:0] exp_q[$];
   int          lat_q[$];

   seq_multdiv #(.WIDTH(8)) u8 (
      .clock(clock), .reset_n(reset_n), .start_mult(m8), .start_div(d8),
      .op_a(a8), .op_b(b8), .result(r8), .result_hi(rh8), .busy(busy8),
      .done(done8), .exception(exc8), .dbg_state(st8)
   );

   seq_multdiv #(.WIDTH(4)) u4 (
      .clock(clock), .reset_n(reset_n), .start_mult(m4), .start_div(d4),
      .op_a(a4), .op_b(b4), .result(r4), .result_hi(rh4), .busy(busy4),
      .done(done4), .exception(exc4), .dbg_state(st4)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference arithmetic; returns {exception, result_hi, result} zero-extended to 32-bit fields.
   function automatic logic [64:0] model(input bit is_div, input int w,
                                         input logic [31:0] a, input logic [31:0] b);
      logic [63:0] mask, ua, ub, up, lo, hi;
      logic        exc;
`ifdef MULTDIV_SIGNED_EN
      longint sa, sb, sp, lim;
`endif
      mask = (64'd1 << w) - 64'd1;
      ua   = {32'd0, a} & mask;
      ub   = {32'd0, b} & mask;
      up   = '0;
`ifdef MULTDIV_SIGNED_EN
      lim = longint'(1) << (w - 1);
      sa  = longint'(ua);
      sb  = longint'(ub);
      if (ua[w-1]) sa = sa - (longint'(1) << w);
      if (ub[w-1]) sb = sb - (longint'(1) << w);
      if (!is_div) begin
         sp  = sa * sb;
         lo  = 64'(sp) & mask;
         hi  = 64'(sp >>> w) & mask;
         exc = (sp < -lim) || (sp >= lim);
      end else if (ub == 0) begin
         lo = mask; hi = ua; exc = 1'b1;
      end else if (sa == -lim && sb == -1) begin
         lo = ua; hi = '0; exc = 1'b1;
      end else begin
         lo  = 64'(sa / sb) & mask;
         hi  = 64'(sa % sb) & mask;
         exc = 1'b0;
      end
`else
      if (!is_div) begin
         up  = ua * ub;
         lo  = up & mask;
         hi  = (up >> w) & mask;
         exc = (hi != 0);
      end else if (ub == 0) begin
         lo = mask; hi = ua; exc = 1'b1;
      end else begin
         lo = ua / ub; hi = ua % ub; exc = 1'b0;
      end
`endif
      return {exc, hi[31:0], lo[31:0]};
   endfunction

   function automatic int model_lat(input bit is_div, input int w, input logic [31:0] b);
      logic [31:0] mask;
      mask = (32'd1 << w) - 32'd1;
      return (is_div && ((b & mask) == 0)) ? 1 : w + 1;
   endfunction

   // Called #1 after an edge; returns #1 after the accepting edge with the start dropped
   // and the operand inputs scrambled.
   task automatic issue(input bit w4, input bit is_div, input logic [31:0] a, input logic [31:0] b);
      if (w4) begin
         m4 = !is_div; d4 = is_div; a4 = a[3:0]; b4 = b[3:0];
      end else begin
         m8 = !is_div; d8 = is_div; a8 = a[7:0]; b8 = b[7:0];
      end
      @(posedge clock);
      #1;
      m4 = 1'b0; d4 = 1'b0; m8 = 1'b0; d8 = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom);
   endtask

   task automatic push_exp(input bit w4, input bit is_div, input logic [31:0] a, input logic [31:0] b);
      exp_q.push_back(model(is_div, w4 ? 4 : 8, a, b));
      lat_q.push_back(model_lat(is_div, w4 ? 4 : 8, b));
   endtask

   // Counts edges after the accepting edge until done is seen; lat = -1 on timeout.
   task automatic wait_done(input bit w4, output int lat, output logic [64:0] got);
      got = '0;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clock);
         #1;
         if (w4 ? done4 : done8) begin
            lat = i;
            got = w4 ? {exc4, 28'd0, rh4, 28'd0, r4} : {exc8, 24'd0, rh8, 24'd0, r8};
            return;
         end
      end
      lat = -1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      #1;
      checks++; if (r8 !== 8'd0)   begin failures++; $display("FAIL reset_result8: got %h expected 00", r8); end
      checks++; if (rh8 !== 8'd0)  begin failures++; $display("FAIL reset_result_hi8: got %h expected 00", rh8); end
      checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy8: got %b expected 0", busy8); end
      checks++; if (done8 !== 1'b0) begin failures++; $display("FAIL reset_done8: got %b expected 0", done8); end
      checks++; if (exc8 !== 1'b0) begin failures++; $display("FAIL reset_exc8: got %b expected 0", exc8); end
      checks++; if (st8 !== 2'd0)  begin failures++; $display("FAIL reset_state8: got %0d expected 0", st8); end
      checks++; if ({r4, rh4, busy4, done4, exc4} !== 11'd0)
         begin failures++; $display("FAIL reset_w4: got %h expected 000", {r4, rh4, busy4, done4, exc4}); end
      @(posedge clock);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_exhaustive4;
      int          lat, exp_lat;
      logic [64:0] got, exp_v;
      for (int k = 0; k < 2; k++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               push_exp(1'b1, k[0], 32'(a), 32'(b));
               issue(1'b1, k[0], 32'(a), 32'(b));
               wait_done(1'b1, lat, got);
               exp_v   = exp_q.pop_front();
               exp_lat = lat_q.pop_front();
               checks++;
               if (got !== exp_v) begin
                  failures++;
                  $display("FAIL exh4_%s a=%0d b=%0d: got %h expected %h", k ? "div" : "mul", a, b, got, exp_v);
               end
               checks++;
               if (lat !== exp_lat) begin
                  failures++;
                  $display("FAIL exh4_lat a=%0d b=%0d: got %0d expected %0d", a, b, lat, exp_lat);
               end
               @(posedge clock);
               #1;
            end
         end
      end
   endtask

   task automatic test_div_zero;
      int          lat;
      logic [64:0] got, exp_v;
      push_exp(1'b0, 1'b1, 32'd200, 32'd0);
      issue(1'b0, 1'b1, 32'd200, 32'd0);
      checks++; if (busy8 !== 1'b1) begin failures++; $display("FAIL divzero_busy: got %b expected 1", busy8); end
      wait_done(1'b0, lat, got);
      exp_v = exp_q.pop_front();
      void'(lat_q.pop_front());
      checks++; if (lat !== 1) begin failures++; $display("FAIL divzero_lat: got %0d expected 1", lat); end
      checks++; if (got !== {1'b1, 32'd200, 32'h0000_00FF})
         begin failures++; $display("FAIL divzero_value: got %h expected %h", got, {1'b1, 32'd200, 32'hFF}); end
      checks++; if (got !== exp_v) begin failures++; $display("FAIL divzero_model: got %h expected %h", got, exp_v); end
      @(posedge clock);
      #1;
   endtask

   task automatic test_ignore_start;
      int          lat;
      logic [64:0] got, exp_v;
      push_exp(1'b0, 1'b0, 32'd15, 32'd17);
      issue(1'b0, 1'b0, 32'd15, 32'd17);
      lat = -1;
      got = '0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clock);
         #1;
         d8 = 1'b0;
         if (done8) begin
            lat = i;
            got = {exc8, 24'd0, rh8, 24'd0, r8};
            break;
         end
         if (i == 2) begin
            d8 = 1'b1; a8 = 8'd100; b8 = 8'd3;
         end
      end
      exp_v = exp_q.pop_front();
      void'(lat_q.pop_front());
      checks++; if (lat !== 9) begin failures++; $display("FAIL ignore_lat: got %0d expected 9", lat); end
      checks++; if (got[31:0] !== 32'd255 || got[63:32] !== 32'd0)
         begin failures++; $display("FAIL ignore_value: got %h expected hi=0 lo=ff", got[63:0]); end
      checks++; if (got !== exp_v) begin failures++; $display("FAIL ignore_model: got %h expected %h", got, exp_v); end
      @(posedge clock);
      #1;
      checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL ignore_idle: got busy %b expected 0", busy8); end
   endtask

   task automatic test_back_to_back;
      int          lat;
      logic [64:0] got, exp_v;
      logic [7:0]  first_lo;
      push_exp(1'b0, 1'b0, 32'd13, 32'd11);
      issue(1'b0, 1'b0, 32'd13, 32'd11);
      wait_done(1'b0, lat, got);
      exp_v = exp_q.pop_front();
      void'(lat_q.pop_front());
      checks++; if (got !== exp_v) begin failures++; $display("FAIL b2b_first: got %h expected %h", got, exp_v); end
      first_lo = exp_v[7:0];
      @(posedge clock);
      #1;
      push_exp(1'b0, 1'b1, 32'd100, 32'd7);
      issue(1'b0, 1'b1, 32'd100, 32'd7);
      checks++; if (busy8 !== 1'b1) begin failures++; $display("FAIL b2b_accept: got busy %b expected 1", busy8); end
      checks++; if (r8 !== first_lo) begin failures++; $display("FAIL b2b_hold_old: got %h expected %h", r8, first_lo); end
      wait_done(1'b0, lat, got);
      exp_v = exp_q.pop_front();
      void'(lat_q.pop_front());
      checks++; if (lat !== 9) begin failures++; $display("FAIL b2b_lat: got %0d expected 9", lat); end
      checks++; if (got !== exp_v) begin failures++; $display("FAIL b2b_second: got %h expected %h", got, exp_v); end
      repeat (4) @(posedge clock);
      #1;
      checks++; if ({exc8, rh8, r8} !== {exp_v[64], exp_v[39:32], exp_v[7:0]})
         begin failures++; $display("FAIL b2b_hold_new: got %h expected %h", {exc8, rh8, r8}, {exp_v[64], exp_v[39:32], exp_v[7:0]}); end
   endtask

   task automatic test_reset_abort;
      int          lat;
      logic [64:0] got, exp_v;
      issue(1'b0, 1'b0, 32'd200, 32'd3);
      repeat (3) @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      checks++; if ({r8, rh8, busy8, done8, exc8} !== 19'd0)
         begin failures++; $display("FAIL abort_outputs: got %h expected 00000", {r8, rh8, busy8, done8, exc8}); end
      @(posedge clock);
      #1;
      checks++; if (done8 !== 1'b0) begin failures++; $display("FAIL abort_done: got %b expected 0", done8); end
      reset_n = 1'b1;
      push_exp(1'b0, 1'b0, 32'd12, 32'd12);
      issue(1'b0, 1'b0, 32'd12, 32'd12);
      wait_done(1'b0, lat, got);
      exp_v = exp_q.pop_front();
      void'(lat_q.pop_front());
      checks++; if (lat !== 9) begin failures++; $display("FAIL abort_next_lat: got %0d expected 9", lat); end
      checks++; if (got[31:0] !== 32'd144) begin failures++; $display("FAIL abort_next_result: got %0d expected 144", got[31:0]); end
      checks++; if (got !== exp_v) begin failures++; $display("FAIL abort_next_model: got %h expected %h", got, exp_v); end
      @(posedge clock);
      #1;
   endtask

   task automatic test_random;
      int          lat, exp_lat;
      logic [64:0] got, exp_v;
      logic [31:0] a, b;
      bit          is_div;
      for (int i = 0; i < 24; i++) begin
         is_div = 1'($urandom_range(0, 1));
         a      = 32'($urandom_range(0, 255));
         b      = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 255));
         push_exp(1'b0, is_div, a, b);
         issue(1'b0, is_div, a, b);
         wait_done(1'b0, lat, got);
         exp_v   = exp_q.pop_front();
         exp_lat = lat_q.pop_front();
         checks++;
         if (got !== exp_v) begin
            failures++;
            $display("FAIL rand_%s a=%0d b=%0d: got %h expected %h", is_div ? "div" : "mul", a, b, got, exp_v);
         end
         checks++;
         if (lat !== exp_lat) begin failures++; $display("FAIL rand_lat: got %0d expected %0d", lat, exp_lat); end
         @(posedge clock);
         #1;
      end
      checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL scoreboard_empty: got %0d expected 0", exp_q.size()); end
   endtask

`ifdef MULTDIV_SIGNED_EN
   task automatic test_signed;
      int          lat;
      logic [64:0] got;
      logic [16:0] want [3];
      logic [31:0] sa [3];
      logic [31:0] sb [3];
      bit          sdiv [3];
      want[0] = {1'b0, 8'hFF, 8'hFD}; sa[0] = 32'hF9; sb[0] = 32'h02; sdiv[0] = 1'b1;
      want[1] = {1'b1, 8'h00, 8'h80}; sa[1] = 32'h80; sb[1] = 32'hFF; sdiv[1] = 1'b1;
      want[2] = {1'b0, 8'hFF, 8'hF1}; sa[2] = 32'hFD; sb[2] = 32'h05; sdiv[2] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         issue(1'b0, sdiv[i], sa[i], sb[i]);
         wait_done(1'b0, lat, got);
         checks++;
         if ({got[64], got[39:32], got[7:0]} !== want[i])
            begin failures++; $display("FAIL signed_%0d: got %h expected %h", i, {got[64], got[39:32], got[7:0]}, want[i]); end
         @(posedge clock);
         #1;
      end
   endtask
`endif

   initial begin
      checks = 0;
      failures = 0;
      m8 = 1'b0; d8 = 1'b0; a8 = '0; b8 = '0;
      m4 = 1'b0; d4 = 1'b0; a4 = '0; b4 = '0;
      test_reset();
      test_exhaustive4();
      test_div_zero();
      test_ignore_start();
      test_back_to_back();
      test_reset_abort();
      test_random();
`ifdef MULTDIV_SIGNED_EN
      test_signed();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
